// File: rtl/magnetron.sv
// magnetron: microwave magnetron enable FSM (IDLE/ON/PAUSED) with registered output.
// Optional MAGNETRON_SYNC_EN puts 2-flop synchronizers on startn, stopn, porta_fechada and zero.
module magnetron (
    input  logic clk,
    input  logic clrn,
    input  logic startn,
    input  logic stopn,
    input  logic porta_fechada,
    input  logic zero,
    output logic ligar
);
    typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, PAUSED = 2'd2} state_t;
    state_t r_state, w_next;
    logic   r_ligar;
    logic   w_startn, w_stopn, w_porta, w_zero, w_start_ok;
`ifdef MAGNETRON_SYNC_EN
    logic [1:0] r_startn_s, r_stopn_s, r_porta_s, r_zero_s;
    // synchronizers reset to the inactive level of each input
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_startn_s <= 2'b11;
            r_stopn_s  <= 2'b11;
            r_porta_s  <= 2'b00;
            r_zero_s   <= 2'b00;
        end else begin
            r_startn_s <= {r_startn_s[0], startn};
            r_stopn_s  <= {r_stopn_s[0], stopn};
            r_porta_s  <= {r_porta_s[0], porta_fechada};
            r_zero_s   <= {r_zero_s[0], zero};
        end
    end
    assign w_startn = r_startn_s[1];
    assign w_stopn  = r_stopn_s[1];
    assign w_porta  = r_porta_s[1];
    assign w_zero   = r_zero_s[1];
`else
    assign w_startn = startn;
    assign w_stopn  = stopn;
    assign w_porta  = porta_fechada;
    assign w_zero   = zero;
`endif
    assign w_start_ok = !w_startn && w_stopn && w_porta && !w_zero;
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_start_ok ? ON : IDLE;
            ON:      w_next = !w_stopn ? IDLE : !w_porta ? PAUSED : w_zero ? IDLE : ON;
            PAUSED:  w_next = (!w_stopn || w_zero) ? IDLE : w_start_ok ? ON : PAUSED;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= IDLE;
            r_ligar <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ligar <= (w_next == ON);
        end
    end
    assign ligar = r_ligar;
endmodule

// File: tb/tb_magnetron.sv
// tb_magnetron: directed scenarios plus randomized run against a behavioural model of the oven controller.
module tb_magnetron;
`ifdef MAGNETRON_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    logic clk = 1'b0, clrn = 1'b0, startn = 1'b1, stopn = 1'b1, porta_fechada = 1'b1, zero = 1'b0;
    logic ligar;
    int   checks = 0, failures = 0;
    int   mode = 0;
    logic [3:0] pipe[$];

    magnetron dut (.clk(clk), .clrn(clrn), .startn(startn), .stopn(stopn),
                   .porta_fechada(porta_fechada), .zero(zero), .ligar(ligar));

    always #5 clk = ~clk;

    // mode: 0 idle, 1 cooking, 2 paused; pipe models input delay to the controller
    task automatic model_reset();
        mode = 0;
        pipe.delete();
        for (int i = 0; i < LAT - 1; i++) pipe.push_back(4'b1100);
    endtask

    task automatic model_edge();
        logic [3:0] e;
        logic ok;
        pipe.push_back({startn, stopn, porta_fechada, zero});
        e  = pipe.pop_front();
        ok = !e[3] && e[2] && e[1] && !e[0];
        if (mode == 0) begin
            if (ok) mode = 1;
        end else if (mode == 1) begin
            if (!e[2]) mode = 0;
            else if (!e[1]) mode = 2;
            else if (e[0]) mode = 0;
        end else begin
            if (!e[2] || e[0]) mode = 0;
            else if (ok) mode = 1;
        end
    endtask

    task automatic step(input logic s, input logic p, input logic d, input logic z);
        startn = s; stopn = p; porta_fechada = d; zero = z;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic hold(input logic s, input logic p, input logic d, input logic z);
        repeat (LAT) step(s, p, d, z);
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        model_reset();
        #20;
        clrn = 1'b1;
    endtask

    task automatic test_reset();
        startn = 1'b0;
        do_reset();
        checks++;
        if (ligar !== 1'b0) begin failures++; $display("FAIL reset ligar=%0b expected=0", ligar); end
    endtask

    task automatic test_normal_start();
        do_reset();
        step(1, 1, 1, 0);
        checks++;
        if (ligar !== 1'b0) begin failures++; $display("FAIL start_pre ligar=%0b expected=0", ligar); end
        for (int i = 0; i < LAT - 1; i++) begin
            step(0, 1, 1, 0);
            checks++;
            if (ligar !== 1'b0) begin failures++; $display("FAIL start_latency ligar=%0b expected=0", ligar); end
        end
        step(0, 1, 1, 0);
        checks++;
        if (ligar !== 1'b1) begin failures++; $display("FAIL start_edge ligar=%0b expected=1", ligar); end
        repeat (5) step(1, 1, 1, 0);
        checks++;
        if (ligar !== 1'b1) begin failures++; $display("FAIL start_release ligar=%0b expected=1", ligar); end
    endtask

    task automatic test_door_open();
        hold(1, 1, 0, 0);
        checks++;
        if (ligar !== 1'b0) begin failures++; $display("FAIL door_pause ligar=%0b expected=0", ligar); end
        repeat (LAT + 2) step(1, 1, 1, 0);
        checks++;
        if (ligar !== 1'b0) begin failures++; $display("FAIL door_close_no_resume ligar=%0b expected=0", ligar); end
        hold(0, 1, 1, 0);
        checks++;
        if (ligar !== 1'b1) begin failures++; $display("FAIL door_restart ligar=%0b expected=1", ligar); end
        hold(1, 1, 1, 0);
    endtask

    task automatic test_timer();
        hold(1, 1, 1, 1);
        checks++;
        if (ligar !== 1'b0) begin failures++; $display("FAIL timer_zero ligar=%0b expected=0", ligar); end
        repeat (LAT + 2) step(1, 1, 1, 0);
        checks++;
        if (ligar !== 1'b0) begin failures++; $display("FAIL timer_no_resume ligar=%0b expected=0", ligar); end
    endtask

    task automatic test_clear();
        hold(0, 1, 1, 0);
        checks++;
        if (ligar !== 1'b1) begin failures++; $display("FAIL clear_setup ligar=%0b expected=1", ligar); end
        #2;
        clrn = 1'b0; startn = 1'b0;
        #1;
        checks++;
        if (ligar !== 1'b0) begin failures++; $display("FAIL clear_async ligar=%0b expected=0", ligar); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ligar !== 1'b0) begin failures++; $display("FAIL clear_hold ligar=%0b expected=0", ligar); end
        model_reset();
        startn = 1'b1;
        clrn = 1'b1;
    endtask

    task automatic test_blocked();
        do_reset();
        repeat (LAT + 1) step(0, 1, 0, 0);
        checks++;
        if (ligar !== 1'b0) begin failures++; $display("FAIL blocked_door ligar=%0b expected=0", ligar); end
        repeat (LAT + 1) step(0, 0, 1, 0);
        checks++;
        if (ligar !== 1'b0) begin failures++; $display("FAIL blocked_stop ligar=%0b expected=0", ligar); end
        repeat (LAT + 1) step(0, 1, 1, 1);
        checks++;
        if (ligar !== 1'b0) begin failures++; $display("FAIL blocked_zero ligar=%0b expected=0", ligar); end
        repeat (LAT) step(1, 1, 1, 0);
    endtask

    task automatic test_random();
        logic exp;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                #2;
                clrn = 1'b0;
                #1;
                checks++;
                if (ligar !== 1'b0) begin failures++; $display("FAIL rand_clear n=%0d ligar=%0b expected=0", n, ligar); end
                model_reset();
                clrn = 1'b1;
            end
            step($urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 5) != 0, $urandom_range(0, 7) == 0);
            exp = (mode == 1);
            checks++;
            if (ligar !== exp) begin failures++; $display("FAIL rand n=%0d ligar=%0b expected=%0b", n, ligar, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_normal_start();
        test_door_open();
        test_timer();
        test_clear();
        test_blocked();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/magnetron.md
Name: magnetron

Overview:
- Control block that turns the microwave magnetron on and off.
- Sits between the front-panel buttons (start, stop, clear), the door sensor and the countdown timer's zero flag, and drives the magnetron enable.
- Implemented as a small synchronous state machine with a registered output.

Parameters:
- none (fixed widths; behaviour selected only by the optional macro)

Ports:
- clk  input  1  system clock; all state changes occur on its rising edge
- clrn  input  1  asynchronous active-low reset/clear (front-panel clear button); forces the idle state immediately
- startn  input  1  start button, active-low, level-sensitive
- stopn  input  1  stop button, active-low, level-sensitive
- porta_fechada  input  1  door sensor; 1 = door closed, 0 = door open
- zero  input  1  timer-expired flag from the countdown; 1 = time is 0
- ligar  output  1  magnetron enable; 1 = magnetron on; registered

Interface decision: one clock (clk); reset is asynchronous and active-low (clrn).

Behaviour:
- States:
  - IDLE (reset state): ligar=0.
  - ON: ligar=1.
  - PAUSED: ligar=0; entered when the door opens during cooking.
- Reset: clrn=0 forces state=IDLE and ligar=0 asynchronously. Clear overrides every other input, including startn=0. The FSM leaves reset on the first clk edge after clrn returns to 1.
- Define start_ok = (startn==0) & (stopn==1) & (porta_fechada==1) & (zero==0).
- IDLE:
  - start_ok -> ON.
  - Otherwise stay in IDLE.
- ON, priority highest first:
  - stopn==0 -> IDLE.
  - porta_fechada==0 -> PAUSED.
  - zero==1 -> IDLE.
  - Otherwise stay in ON. Holding startn low while in ON has no effect.
- PAUSED, priority highest first:
  - stopn==0 -> IDLE.
  - zero==1 -> IDLE.
  - start_ok -> ON. The door must be closed and start pressed again; closing the door alone does not resume.
  - Otherwise stay in PAUSED.
- Simultaneous events: stop beats door-open, door-open beats zero, zero beats start. A start request is ignored in the same cycle as stopn==0, the door open, or zero==1.
- Latency: ligar is registered from the next-state value. It changes on the first rising clk edge at which the qualifying inputs are sampled, i.e. one cycle of latency. The reset path has zero-cycle latency (asynchronous).
- Output rule: ligar == (state==ON) at all times. The output never glitches because it comes from a flop.
- Unused state encoding: any illegal state value goes to IDLE on the next edge with ligar=0.

Optional Feature:
- Macro: MAGNETRON_SYNC_EN.
- Defined:
  - startn, stopn, porta_fechada and zero each pass through a 2-flop synchronizer clocked by clk before reaching the FSM.
  - The synchronizer flops reset asynchronously on clrn=0 to their inactive values: startn=1, stopn=1, porta_fechada=0, zero=0.
  - Input-to-ligar latency becomes 3 clk edges.
  - clrn is not synchronized and stays asynchronous.
- Not defined: inputs feed the FSM directly and latency is 1 edge.

Test Plan (clk period 10 ns; latencies given without MAGNETRON_SYNC_EN):
- Normal start: clrn=0 for 20 ns, then clrn=1, startn=1, stopn=1, porta_fechada=1, zero=0; drive startn=0 for 50 ns -> ligar=1 one edge after startn=0 is sampled, and it stays 1 after startn returns to 1.
- Door open: from ON, drive porta_fechada=0 -> ligar=0 next edge (PAUSED). Then porta_fechada=1 with startn=1 -> ligar stays 0. Then startn=0 -> ligar=1 next edge.
- Timer expiry: from ON, drive zero=1 -> ligar=0 next edge. Then zero=0 without pressing start -> ligar stays 0.
- Clear priority: from ON, drive clrn=0 together with startn=0 -> ligar=0 immediately, with no clock edge needed, and it stays 0 while clrn=0.
- Start blocked: in IDLE, drive startn=0 with porta_fechada=0 -> ligar stays 0. Repeat with stopn=0 and porta_fechada=1 -> ligar stays 0. Repeat with zero=1 -> ligar stays 0.
- Sync option: with MAGNETRON_SYNC_EN defined, repeat the normal-start scenario -> ligar rises exactly 3 edges after startn=0 is applied.
